// File: rtl/ecc_result_fifo.sv
// ecc_result_fifo: captures {err, data} on each op_done rising edge into a
// FWFT fifo with valid/ready read port and saturating result statistics.
//
// Ports:
//   clk, rst (async, active low)
//   op_done, data_in, err_in   capture side from the ECC top
//   clr                        sync clear of fifo, counters, overflow
//   out_valid/out_ready        FWFT read handshake, out_data/out_err head
//   level, full, empty         occupancy status
//   overflow                   sticky: a capture was dropped on full
//   cnt_clean/corr/uncorr      saturating result counters
module ecc_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_done,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [1:0]              err_in,
  input  logic                    clr,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [1:0]              out_err,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic [CNT_WIDTH-1:0]    cnt_clean,
  output logic [CNT_WIDTH-1:0]    cnt_corr,
  output logic [CNT_WIDTH-1:0]    cnt_uncorr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          op_done_q;
  logic          hold_q;
  logic          cap;
  logic          pop;
  logic          push;
  logic          do_push;
  logic          do_pop;
  logic          do_cap;

  // hold_q blocks a level still high across reset from looking like an edge
  assign cap     = op_done & ~op_done_q & ~hold_q;
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign out_valid = ~empty;
  assign pop     = out_valid & out_ready;
  // a pop in the same cycle frees the slot, so a full fifo still accepts
  assign push    = cap & (~full | pop);
  assign do_push = push & ~clr;
  assign do_pop  = pop & ~clr;
  assign do_cap  = cap & ~clr;
  assign level   = level_q;

  assign out_data = out_valid ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
  assign out_err  = out_valid ? mem[rd_ptr][EW-1:DATA_WIDTH] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_done_q <= 1'b0;
      hold_q    <= 1'b1;
    end else begin
      op_done_q <= op_done;
      if (!op_done) hold_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {err_in, data_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (!do_push && do_pop) level_q <= level_q - LW'(1);
      if (cap && !push) overflow <= 1'b1;
    end
  end

  logic inc_clean;
  logic inc_corr;
  logic inc_uncorr;

  always_comb begin
    inc_clean  = 1'b0;
    inc_corr   = 1'b0;
    inc_uncorr = 1'b0;
    if (do_cap) begin
      unique case (1'b1)
        (err_in == 2'b00): inc_clean  = 1'b1;
        (err_in == 2'b01): inc_corr   = 1'b1;
        err_in[1]:         inc_uncorr = 1'b1;
        default:           ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_clean  <= '0;
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (clr) begin
      cnt_clean  <= '0;
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else begin
      if (inc_clean && cnt_clean != '1)
        cnt_clean <= cnt_clean + CNT_WIDTH'(1);
      if (inc_corr && cnt_corr != '1)
        cnt_corr <= cnt_corr + CNT_WIDTH'(1);
      if (inc_uncorr && cnt_uncorr != '1)
        cnt_uncorr <= cnt_uncorr + CNT_WIDTH'(1);
    end
  end

endmodule
